// File: rtl/accum_pkg.sv
// accum_pkg: shared definitions for the integrate-and-dump accumulator.
//   state_e   : FSM states (ACCUM collects samples, HOLD presents a result)
//   frame_max : number of samples a frame holds when dump_len is 0
package accum_pkg;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   // A dump_len of 0 stands for the full 2^len_width samples.
   function automatic int unsigned frame_max(input int unsigned len_width);
      return 32'd1 << len_width;
   endfunction

endpackage

// File: rtl/accum_alu.sv
// accum_alu: one add/subtract step of the accumulator.
//   acc    : current accumulator value
//   sample : unsigned input sample, zero-extended to the accumulator width
//   sub    : 1 = subtract sample, 0 = add
//   sat_en : 1 = clamp to 0 / all-ones on overflow, 0 = wrap
//   nxt    : next accumulator value
//   ovf    : carry out of an add or borrow out of a subtract
module accum_alu #(
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned ACC_WIDTH = 8
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [IN_WIDTH-1:0]  sample,
   input  logic                 sub,
   input  logic                 sat_en,
   output logic [ACC_WIDTH-1:0] nxt,
   output logic                 ovf
);

   logic [ACC_WIDTH:0] acc_ext;
   logic [ACC_WIDTH:0] smp_ext;
   logic [ACC_WIDTH:0] sum;

   always_comb begin
      acc_ext = {1'b0, acc};
      smp_ext = (ACC_WIDTH+1)'(sample);
      sum     = sub ? (acc_ext - smp_ext) : (acc_ext + smp_ext);
      // Both operands are below 2^ACC_WIDTH, so the top bit is the carry
      // for an add and the borrow for a subtract.
      ovf     = sum[ACC_WIDTH];
      if (ovf && sat_en) begin
         nxt = sub ? '0 : '1;
      end else begin
         nxt = sum[ACC_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/accum_dump.sv
// accum_dump: integrate-and-dump accumulator with valid/ready on both sides.
//   clk, clear            : clock, synchronous active-high reset
//   in_valid/in_ready     : sample handshake; in_data, in_sub, sat_en per sample
//   dump_len              : frame length (0 = 2^LEN_WIDTH), latched on first sample
//   flush                 : close the current non-empty frame early
//   out_valid/out_ready   : result handshake; out_data, out_count, out_ovf
//   acc_q                 : running accumulator (frame total while holding)
module accum_dump
   import accum_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned ACC_WIDTH = 8,
   parameter int unsigned LEN_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_sub,
   input  logic                 sat_en,
   input  logic [LEN_WIDTH-1:0] dump_len,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic [LEN_WIDTH:0]   out_count,
   output logic                 out_ovf,
   output logic [ACC_WIDTH-1:0] acc_q
);

   localparam logic [LEN_WIDTH:0] LEN_FULL = (LEN_WIDTH+1)'(frame_max(LEN_WIDTH));

   state_e                 state_q;
   logic [LEN_WIDTH:0]     cnt_q;
   logic [LEN_WIDTH:0]     len_q;
   logic                   ovf_q;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic [ACC_WIDTH-1:0]   out_data_q;
   logic [LEN_WIDTH:0]     out_count_q;
   logic                   out_ovf_q;

   logic                   accept;
   logic [LEN_WIDTH:0]     len_in;
   logic [LEN_WIDTH:0]     len_eff;
   logic [ACC_WIDTH-1:0]   alu_nxt;
   logic                   alu_ovf;
   logic [ACC_WIDTH-1:0]   acc_d;
   logic [LEN_WIDTH:0]     cnt_d;
   logic                   ovf_d;
   logic                   frame_end;

   accum_alu #(
      .IN_WIDTH  (IN_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_alu (
      .acc    (acc_q),
      .sample (in_data),
      .sub    (in_sub),
      .sat_en (sat_en),
      .nxt    (alu_nxt),
      .ovf    (alu_ovf)
   );

   always_comb begin
      accept    = in_valid && in_ready_q;
      len_in    = (dump_len == '0) ? LEN_FULL : {1'b0, dump_len};
      // First sample of a frame uses the live length; later ones the latched copy.
      len_eff   = (cnt_q == '0) ? len_in : len_q;
      acc_d     = accept ? alu_nxt : acc_q;
      cnt_d     = cnt_q + (LEN_WIDTH+1)'(accept);
      ovf_d     = ovf_q || (accept && alu_ovf);
      frame_end = (accept && (cnt_d == len_eff)) || (flush && (cnt_d != '0));
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               in_ready_q <= 1'b1;
               acc_q      <= acc_d;
               cnt_q      <= cnt_d;
               ovf_q      <= ovf_d;
               if (accept && (cnt_q == '0)) begin
                  len_q <= len_in;
               end
               if (frame_end) begin
                  state_q     <= ST_HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= acc_d;
                  out_count_q <= cnt_d;
                  out_ovf_q   <= ovf_d;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_q     <= ST_ACCUM;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  ovf_q       <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_ACCUM;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_accum_dump.sv
module tb_accum_dump;

   logic       clk = 1'b0;
   logic       clear;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_sub;
   logic       sat_en;
   logic [3:0] dump_len;
   logic       flush;
   logic       out_ready;

   logic       in_ready8, out_valid8, out_ovf8;
   logic [7:0] out_data8, acc_q8;
   logic [4:0] out_count8;

   logic       in_ready6, out_valid6, out_ovf6;
   logic [5:0] out_data6, acc_q6;
   logic [4:0] out_count6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   accum_dump #(.IN_WIDTH(4), .ACC_WIDTH(8), .LEN_WIDTH(4)) dut8 (
      .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
      .in_data(in_data), .in_sub(in_sub), .sat_en(sat_en), .dump_len(dump_len),
      .flush(flush), .out_valid(out_valid8), .out_ready(out_ready),
      .out_data(out_data8), .out_count(out_count8), .out_ovf(out_ovf8), .acc_q(acc_q8)
   );

   accum_dump #(.IN_WIDTH(4), .ACC_WIDTH(6), .LEN_WIDTH(4)) dut6 (
      .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
      .in_data(in_data), .in_sub(in_sub), .sat_en(sat_en), .dump_len(dump_len),
      .flush(flush), .out_valid(out_valid6), .out_ready(out_ready),
      .out_data(out_data6), .out_count(out_count6), .out_ovf(out_ovf6), .acc_q(acc_q6)
   );

   typedef struct {
      logic [3:0]  len;
      logic        sat;
      int          n;
      logic [15:0] d;     // sample i in nibble i
      logic [3:0]  s;     // subtract flag for sample i in bit i
      logic [7:0]  data;
      logic [4:0]  cnt;
      logic        ovf;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one sample and return #1 after the edge that accepts it.
   task automatic send(input logic [3:0] d, input logic s, input logic sat);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = s;
      sat_en   = sat;
      n = 0;
      while (in_ready8 !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stuck at %0d, required 1", in_ready8);
      end
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{len:4'd3, sat:1'b0, n:3, d:16'h0975, s:4'b0000, data:8'd21,  cnt:5'd3, ovf:1'b0};
      vecs[1] = '{len:4'd1, sat:1'b0, n:1, d:16'h0003, s:4'b0001, data:8'd253, cnt:5'd1, ovf:1'b1};
      vecs[2] = '{len:4'd1, sat:1'b1, n:1, d:16'h0003, s:4'b0001, data:8'd0,   cnt:5'd1, ovf:1'b1};
      vecs[3] = '{len:4'd4, sat:1'b0, n:4, d:16'h25FF, s:4'b1100, data:8'd23,  cnt:5'd4, ovf:1'b0};
      vecs[4] = '{len:4'd2, sat:1'b1, n:2, d:16'h0041, s:4'b0001, data:8'd4,   cnt:5'd2, ovf:1'b1};
      vecs[5] = '{len:4'd2, sat:1'b0, n:2, d:16'h00FF, s:4'b0010, data:8'd0,   cnt:5'd2, ovf:1'b0};

      clear = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; sat_en = 1'b0;
      dump_len = 4'd3; flush = 1'b0; out_ready = 1'b1;
      step(); step();
      chk("rst_out_valid", out_valid8, 0);
      chk("rst_out_data", out_data8, 0);
      chk("rst_out_count", out_count8, 0);
      chk("rst_out_ovf", out_ovf8, 0);
      chk("rst_acc", acc_q8, 0);
      chk("rst_in_ready", in_ready8, 0);
      clear = 1'b0;
      step();
      chk("rst_in_ready_after", in_ready8, 1);

      // Table-driven frames on the 8-bit accumulator
      for (int k = 0; k < 6; k++) begin
         dump_len = vecs[k].len;
         for (int i = 0; i < vecs[k].n; i++) begin
            send(vecs[k].d[i*4 +: 4], vecs[k].s[i], vecs[k].sat);
            if (i < vecs[k].n - 1) chk($sformatf("v%0d_midvalid", k), out_valid8, 0);
         end
         chk($sformatf("v%0d_valid", k), out_valid8, 1);
         chk($sformatf("v%0d_data", k), out_data8, vecs[k].data);
         chk($sformatf("v%0d_count", k), out_count8, vecs[k].cnt);
         chk($sformatf("v%0d_ovf", k), out_ovf8, vecs[k].ovf);
         chk($sformatf("v%0d_acc", k), acc_q8, vecs[k].data);
         step();
         chk($sformatf("v%0d_valid_after", k), out_valid8, 0);
         chk($sformatf("v%0d_acc_after", k), acc_q8, 0);
      end

      // Backpressure: result holds, input stalls, pending sample taken after handshake
      dump_len = 4'd3; out_ready = 1'b0;
      send(4'd1, 1'b0, 1'b0); send(4'd2, 1'b0, 1'b0); send(4'd3, 1'b0, 1'b0);
      chk("bp_valid", out_valid8, 1);
      chk("bp_data", out_data8, 6);
      in_valid = 1'b1; in_data = 4'd4; in_sub = 1'b0; dump_len = 4'd1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("bp%0d_valid", c), out_valid8, 1);
         chk($sformatf("bp%0d_data", c), out_data8, 6);
         chk($sformatf("bp%0d_count", c), out_count8, 3);
         chk($sformatf("bp%0d_in_ready", c), in_ready8, 0);
      end
      out_ready = 1'b1;
      step();
      chk("bp_hs_valid", out_valid8, 0);
      chk("bp_hs_in_ready", in_ready8, 1);
      chk("bp_hs_acc", acc_q8, 0);
      step();
      in_valid = 1'b0;
      chk("bp_next_valid", out_valid8, 1);
      chk("bp_next_data", out_data8, 4);
      chk("bp_next_count", out_count8, 1);
      step();
      chk("bp_next_done", out_valid8, 0);

      // Flush alone after two samples
      dump_len = 4'd5;
      send(4'd4, 1'b0, 1'b0); send(4'd6, 1'b0, 1'b0);
      chk("fl_acc", acc_q8, 10);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid", out_valid8, 1);
      chk("fl_data", out_data8, 10);
      chk("fl_count", out_count8, 2);
      step();

      // Flush together with a sample
      send(4'd4, 1'b0, 1'b0);
      in_valid = 1'b1; in_data = 4'd3; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("fls_valid", out_valid8, 1);
      chk("fls_data", out_data8, 7);
      chk("fls_count", out_count8, 2);
      step();

      // Flush on an empty frame
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fle_valid0", out_valid8, 0);
      step();
      chk("fle_valid1", out_valid8, 0);
      chk("fle_in_ready", in_ready8, 1);

      // Clear mid-frame
      send(4'd2, 1'b0, 1'b0); send(4'd3, 1'b0, 1'b0);
      chk("clm_acc_before", acc_q8, 5);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clm_acc", acc_q8, 0);
      chk("clm_valid", out_valid8, 0);
      dump_len = 4'd1;
      send(4'd5, 1'b0, 1'b0);
      chk("clm_fresh_valid", out_valid8, 1);
      chk("clm_fresh_data", out_data8, 5);
      chk("clm_fresh_count", out_count8, 1);
      chk("clm_fresh_ovf", out_ovf8, 0);
      step();

      // Clear while holding a result
      out_ready = 1'b0;
      send(4'd9, 1'b0, 1'b0);
      chk("clh_valid_before", out_valid8, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clh_valid", out_valid8, 0);
      chk("clh_data", out_data8, 0);
      chk("clh_count", out_count8, 0);
      chk("clh_ovf", out_ovf8, 0);
      chk("clh_acc", acc_q8, 0);
      out_ready = 1'b1;
      step();

      // Six-bit accumulator: saturate and wrap on 5 x 15
      dump_len = 4'd5;
      for (int i = 0; i < 5; i++) send(4'd15, 1'b0, 1'b1);
      chk("w6s_valid", out_valid6, 1);
      chk("w6s_data", out_data6, 63);
      chk("w6s_ovf", out_ovf6, 1);
      chk("w8s_data", out_data8, 75);
      chk("w8s_ovf", out_ovf8, 0);
      step();
      for (int i = 0; i < 5; i++) send(4'd15, 1'b0, 1'b0);
      chk("w6w_data", out_data6, 11);
      chk("w6w_ovf", out_ovf6, 1);
      chk("w6w_count", out_count6, 5);
      step();

      // dump_len = 0 means a 16-sample frame
      dump_len = 4'd0;
      for (int i = 0; i < 16; i++) begin
         send(4'd1, 1'b0, 1'b0);
         if (i == 14) chk("len16_not_yet", out_valid6, 0);
      end
      chk("len16_valid", out_valid6, 1);
      chk("len16_data6", out_data6, 16);
      chk("len16_count6", out_count6, 16);
      chk("len16_data8", out_data8, 16);
      chk("len16_count8", out_count8, 16);
      step();
      chk("len16_done", out_valid6, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
